// File: rtl/bresenham_ray.sv
// Grid ray walker: traces the Bresenham line from a sensor cell to a hit cell
// in any octant and emits each on-map cell over a valid/ready handshake.
module bresenham_ray #(
  parameter int X_BITS    = 5,
  parameter int Y_BITS    = 4,
  parameter int COORD_W   = 16,
  parameter int MAX_STEPS = 64,
  parameter bit MARK_HIT  = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic signed [COORD_W-1:0] x0,
  input  logic signed [COORD_W-1:0] y0,
  input  logic signed [COORD_W-1:0] x1,
  input  logic signed [COORD_W-1:0] y1,
  output logic                      cell_valid,
  input  logic                      cell_ready,
  output logic [X_BITS-1:0]         x_index,
  output logic [Y_BITS-1:0]         y_index,
  output logic                      cell_is_free,
  output logic                      busy,
  output logic                      done,
  output logic                      truncated
);

  localparam int W  = COORD_W + 2;
  localparam int SW = $clog2(MAX_STEPS + 1);
  localparam logic signed [W-1:0] ONE      = W'(1);
  localparam logic [SW-1:0]       STEP_ONE = SW'(1);
  localparam logic [SW-1:0]       STEP_LIM = SW'(MAX_STEPS);

  typedef enum logic [2:0] {IDLE, INIT, WALK, EMIT, FINISH} state_t;

  state_t               state_reg, state_next;
  logic signed [W-1:0]  cur_x_reg, cur_x_next;
  logic signed [W-1:0]  cur_y_reg, cur_y_next;
  logic signed [W-1:0]  end_x_reg, end_x_next;
  logic signed [W-1:0]  end_y_reg, end_y_next;
  logic signed [W-1:0]  dx_reg, dx_next;
  logic signed [W-1:0]  dy_reg, dy_next;
  logic signed [W-1:0]  err_reg, err_next;
  logic                 sx_neg_reg, sx_neg_next;
  logic                 sy_neg_reg, sy_neg_next;
  logic [SW-1:0]        steps_reg, steps_next;
  logic                 trunc_reg, trunc_next;
  logic [X_BITS-1:0]    x_index_reg, x_index_next;
  logic [Y_BITS-1:0]    y_index_reg, y_index_next;
  logic                 free_reg, free_next;

  logic signed [W-1:0]  diff_x, diff_y, abs_dx, abs_dy;
  logic signed [W:0]    e2, dx_w, dy_w;
  logic                 step_x, step_y, last, in_grid, do_adv;
  logic signed [W-1:0]  adv_x, adv_y, adv_err;
  logic [SW-1:0]        steps_inc;

  // While in INIT the current position still holds the start cell.
  assign diff_x = end_x_reg - cur_x_reg;
  assign diff_y = end_y_reg - cur_y_reg;
  assign abs_dx = diff_x[W-1] ? -diff_x : diff_x;
  assign abs_dy = diff_y[W-1] ? -diff_y : diff_y;

  assign e2     = {err_reg, 1'b0};
  assign dx_w   = {dx_reg[W-1], dx_reg};
  assign dy_w   = {dy_reg[W-1], dy_reg};
  assign step_x = (e2 > -dy_w);
  assign step_y = (e2 < dy_w);

  assign adv_x   = step_x ? (sx_neg_reg ? cur_x_reg - ONE : cur_x_reg + ONE) : cur_x_reg;
  assign adv_y   = step_y ? (sy_neg_reg ? cur_y_reg - ONE : cur_y_reg + ONE) : cur_y_reg;
  assign adv_err = err_reg - (step_x ? dy_reg : '0) + (step_y ? dx_reg : '0);
  assign steps_inc = steps_reg + STEP_ONE;

  assign last    = (cur_x_reg == end_x_reg) && (cur_y_reg == end_y_reg);
  assign in_grid = (cur_x_reg[W-1:X_BITS] == '0) && (cur_y_reg[W-1:Y_BITS] == '0);

  always_comb begin
    state_next   = state_reg;
    cur_x_next   = cur_x_reg;
    cur_y_next   = cur_y_reg;
    end_x_next   = end_x_reg;
    end_y_next   = end_y_reg;
    dx_next      = dx_reg;
    dy_next      = dy_reg;
    err_next     = err_reg;
    sx_neg_next  = sx_neg_reg;
    sy_neg_next  = sy_neg_reg;
    steps_next   = steps_reg;
    trunc_next   = trunc_reg;
    x_index_next = x_index_reg;
    y_index_next = y_index_reg;
    free_next    = free_reg;
    do_adv       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          cur_x_next = {{2{x0[COORD_W-1]}}, x0};
          cur_y_next = {{2{y0[COORD_W-1]}}, y0};
          end_x_next = {{2{x1[COORD_W-1]}}, x1};
          end_y_next = {{2{y1[COORD_W-1]}}, y1};
          steps_next = '0;
          trunc_next = 1'b0;
          state_next = INIT;
        end
      end
      INIT: begin
        dx_next     = abs_dx;
        dy_next     = abs_dy;
        sx_neg_next = diff_x[W-1];
        sy_neg_next = diff_y[W-1];
        err_next    = abs_dx - abs_dy;
        steps_next  = '0;
        state_next  = WALK;
      end
      WALK: begin
        if (in_grid && (!last || MARK_HIT)) begin
          x_index_next = cur_x_reg[X_BITS-1:0];
          y_index_next = cur_y_reg[Y_BITS-1:0];
          free_next    = !last;
          state_next   = EMIT;
        end else if (last) begin
          state_next = FINISH;
        end else begin
          do_adv = 1'b1;
        end
      end
      EMIT: begin
        if (cell_ready) begin
          if (last) state_next = FINISH;
          else      do_adv     = 1'b1;
        end
      end
      FINISH: begin
        trunc_next = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // The step budget includes the endpoint, so it only bites before the last cell.
    if (do_adv) begin
      cur_x_next = adv_x;
      cur_y_next = adv_y;
      err_next   = adv_err;
      steps_next = steps_inc;
      if (steps_inc == STEP_LIM) begin
        trunc_next = 1'b1;
        state_next = FINISH;
      end else begin
        state_next = WALK;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cur_x_reg   <= '0;
      cur_y_reg   <= '0;
      end_x_reg   <= '0;
      end_y_reg   <= '0;
      dx_reg      <= '0;
      dy_reg      <= '0;
      err_reg     <= '0;
      sx_neg_reg  <= 1'b0;
      sy_neg_reg  <= 1'b0;
      steps_reg   <= '0;
      trunc_reg   <= 1'b0;
      x_index_reg <= '0;
      y_index_reg <= '0;
      free_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cur_x_reg   <= cur_x_next;
      cur_y_reg   <= cur_y_next;
      end_x_reg   <= end_x_next;
      end_y_reg   <= end_y_next;
      dx_reg      <= dx_next;
      dy_reg      <= dy_next;
      err_reg     <= err_next;
      sx_neg_reg  <= sx_neg_next;
      sy_neg_reg  <= sy_neg_next;
      steps_reg   <= steps_next;
      trunc_reg   <= trunc_next;
      x_index_reg <= x_index_next;
      y_index_reg <= y_index_next;
      free_reg    <= free_next;
    end
  end

  assign cell_valid   = (state_reg == EMIT);
  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == FINISH);
  assign truncated    = (state_reg == FINISH) && trunc_reg;
  assign x_index      = x_index_reg;
  assign y_index      = y_index_reg;
  assign cell_is_free = free_reg;

endmodule

// File: tb/tb_bresenham_ray.sv
// Directed-vector bench for bresenham_ray: three builds (default, no hit mark,
// MAX_STEPS=8) driven from one ray table plus reset and stall sequences.
module tb_bresenham_ray;
  localparam int XB = 5;
  localparam int YB = 4;
  localparam int CW = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic signed [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  int sel = 0;

  logic st0, st1, st2;
  logic cv[3], bz[3], dn[3], tr[3], fr[3];
  logic [XB-1:0] xi[3];
  logic [YB-1:0] yi[3];

  assign st0 = start && (sel == 0);
  assign st1 = start && (sel == 1);
  assign st2 = start && (sel == 2);

  always #5 clock = ~clock;

  bresenham_ray u_def (
    .clock(clock), .reset(reset), .start(st0), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .cell_valid(cv[0]), .cell_ready(ready), .x_index(xi[0]), .y_index(yi[0]),
    .cell_is_free(fr[0]), .busy(bz[0]), .done(dn[0]), .truncated(tr[0]));

  bresenham_ray #(.MARK_HIT(1'b0)) u_nohit (
    .clock(clock), .reset(reset), .start(st1), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .cell_valid(cv[1]), .cell_ready(ready), .x_index(xi[1]), .y_index(yi[1]),
    .cell_is_free(fr[1]), .busy(bz[1]), .done(dn[1]), .truncated(tr[1]));

  bresenham_ray #(.MAX_STEPS(8)) u_short (
    .clock(clock), .reset(reset), .start(st2), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .cell_valid(cv[2]), .cell_ready(ready), .x_index(xi[2]), .y_index(yi[2]),
    .cell_is_free(fr[2]), .busy(bz[2]), .done(dn[2]), .truncated(tr[2]));

  // sel picks the build; n/first/last/lfree/trunc are hand-computed.
  typedef struct {
    int sel; int x0; int y0; int x1; int y1;
    int n; int fx; int fy; int lx; int ly; int lfree; int trunc;
    int rnd; int lat; int inj;
  } vec_t;

  vec_t vecs[12];
  int n_vec = 0;
  int n_bad = 0;

  int ex[$], ey[$], ef[$];
  int gx[$], gy[$], gf[$];
  int exp_tr;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference walk of the same line in plain integer arithmetic.
  task automatic model(input int ax0, input int ay0, input int ax1, input int ay1,
                       input int maxs, input int mh);
    int x, y, dx, dy, sx, sy, err, e2, n;
    bit fin, lst;
    ex.delete(); ey.delete(); ef.delete();
    exp_tr = 0;
    dx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy = (ay1 > ay0) ? ay1 - ay0 : ay0 - ay1;
    sx = (ax1 >= ax0) ? 1 : -1;
    sy = (ay1 >= ay0) ? 1 : -1;
    err = dx - dy;
    x = ax0; y = ay0; n = 0; fin = 0;
    while (!fin) begin
      lst = (x == ax1) && (y == ay1);
      if (x >= 0 && x < 32 && y >= 0 && y < 16 && (!lst || mh != 0)) begin
        ex.push_back(x); ey.push_back(y); ef.push_back(lst ? 0 : 1);
      end
      if (lst) fin = 1;
      else begin
        n++;
        if (n == maxs) begin
          exp_tr = 1; fin = 1;
        end else begin
          e2 = 2 * err;
          if (e2 > -dy) begin err -= dy; x += sx; end
          if (e2 < dy)  begin err += dx; y += sy; end
        end
      end
    end
  endtask

  task automatic run_ray(input vec_t v, input int idx);
    int cyc, first_lat, got_tr, hold, saved;
    bit seen_done, stall;
    string tag;
    tag = $sformatf("ray%0d", idx);
    model(v.x0, v.y0, v.x1, v.y1, (v.sel == 2) ? 8 : 64, (v.sel == 1) ? 0 : 1);
    gx.delete(); gy.delete(); gf.delete();
    @(negedge clock);
    sel = v.sel;
    x0 = CW'(v.x0); y0 = CW'(v.y0); x1 = CW'(v.x1); y1 = CW'(v.y1);
    ready = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 1; first_lat = -1; got_tr = -1; seen_done = 0; stall = 0; saved = 0;
    check({tag, "_busy"}, int'(bz[sel]), 1);
    while (!seen_done && cyc < 3000) begin
      hold = (int'(cv[sel]) << 12) | (int'(xi[sel]) << 5) | (int'(yi[sel]) << 1) | int'(fr[sel]);
      if (stall) check({tag, "_stall_hold"}, hold, saved);
      if (cv[sel] && first_lat < 0) first_lat = cyc;
      if (dn[sel]) begin
        seen_done = 1;
        got_tr = int'(tr[sel]);
      end
      ready = (v.rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v.inj != 0 && cyc == 9) begin
        x0 = 16'sd1; y0 = 16'sd1; x1 = 16'sd2; y1 = 16'sd2;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      stall = 0;
      if (cv[sel]) begin
        if (ready) begin
          gx.push_back(int'(xi[sel])); gy.push_back(int'(yi[sel])); gf.push_back(int'(fr[sel]));
        end else begin
          stall = 1;
          saved = hold;
        end
      end
      if (!seen_done) begin
        @(negedge clock);
        cyc++;
      end
    end
    start = 1'b0;
    if (!seen_done) check({tag, "_timeout"}, 0, 1);
    check({tag, "_trunc"}, got_tr, v.trunc);
    check({tag, "_count"}, gx.size(), v.n);
    if (gx.size() == ex.size()) begin
      foreach (gx[i]) begin
        check($sformatf("%s_cell%0d", tag, i),
              (gx[i] << 8) | (gy[i] << 1) | gf[i], (ex[i] << 8) | (ey[i] << 1) | ef[i]);
      end
    end else begin
      check({tag, "_model_count"}, gx.size(), ex.size());
    end
    if (v.n > 0 && gx.size() > 0) begin
      check({tag, "_first"}, (gx[0] << 8) | gy[0], (v.fx << 8) | v.fy);
      check({tag, "_last"}, (gx[gx.size()-1] << 8) | (gy[gy.size()-1] << 1) | gf[gf.size()-1],
            (v.lx << 8) | (v.ly << 1) | v.lfree);
    end
    if (v.lat != 0) check({tag, "_latency"}, first_lat, 3);
    @(negedge clock);
    check({tag, "_idle_after"}, (int'(bz[sel]) << 1) | int'(dn[sel]), 0);
    $display("ray %0d sel=%0d (%0d,%0d)->(%0d,%0d): %0d cells, truncated=%0d",
             idx, v.sel, v.x0, v.y0, v.x1, v.y1, gx.size(), got_tr);
  endtask

  initial begin
    int w;
    vecs[0]  = '{0,  0,  0,  5,  0,  6,  0,  0,  5,  0, 0, 0, 0, 1, 0};
    vecs[1]  = '{0,  3, 10,  0,  2,  9,  3, 10,  0,  2, 0, 0, 0, 1, 0};
    vecs[2]  = '{0, -2, -1,  3,  1,  4,  0,  0,  3,  1, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, -2, -1,  3,  1,  3,  0,  0,  2,  0, 1, 0, 0, 0, 0};
    vecs[4]  = '{0,  0,  0, 31, 15, 32,  0,  0, 31, 15, 0, 0, 1, 0, 1};
    vecs[5]  = '{2,  0,  0, 20,  0,  8,  0,  0,  7,  0, 1, 1, 0, 1, 0};
    vecs[6]  = '{2,  0,  0,  7,  0,  8,  0,  0,  7,  0, 0, 0, 0, 1, 0};
    vecs[7]  = '{0,  4,  4,  4,  4,  1,  4,  4,  4,  4, 0, 0, 0, 1, 0};
    vecs[8]  = '{1,  4,  4,  4,  4,  0,  0,  0,  0,  0, 0, 0, 0, 0, 0};
    vecs[9]  = '{0, -5, -5, -1, -3,  0,  0,  0,  0,  0, 0, 0, 0, 0, 0};
    vecs[10] = '{0, 10,  5,  2,  9,  9, 10,  5,  2,  9, 0, 0, 0, 1, 0};
    vecs[11] = '{0, 28,  3, 40,  3,  4, 28,  3, 31,  3, 1, 0, 0, 1, 0};

    repeat (2) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_state%0d", i),
            (int'(cv[i]) << 14) | (int'(bz[i]) << 13) | (int'(dn[i]) << 12) | (int'(tr[i]) << 11) |
            (int'(fr[i]) << 10) | (int'(xi[i]) << 4) | int'(yi[i]), 0);
    end
    reset = 1'b1;

    for (int i = 0; i < 12; i++) run_ray(vecs[i], i);

    // Reset while a cell is being offered, then a clean ray afterwards.
    @(negedge clock);
    sel = 0; x0 = 16'sd0; y0 = 16'sd0; x1 = 16'sd31; y1 = 16'sd15;
    ready = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    w = 0;
    while (!cv[0] && w < 20) begin
      @(negedge clock);
      w++;
    end
    check("midray_valid_before_reset", int'(cv[0]), 1);
    #2 reset = 1'b0;
    #1;
    check("midray_reset_outputs",
          (int'(cv[0]) << 3) | (int'(bz[0]) << 2) | (int'(dn[0]) << 1) | int'(tr[0]), 0);
    check("midray_reset_index", (int'(xi[0]) << 4) | int'(yi[0]), 0);
    @(negedge clock);
    check("midray_no_done", int'(dn[0]), 0);
    reset = 1'b1;
    run_ray(vecs[0], 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bresenham_ray.md
Name: bresenham_ray

Overview:
Parametrised grid ray tracer, successor to the fixed 32x16 LIDAR cell marker. Given integer sensor and hit cells, walks the Bresenham line in all eight octants. Emits one cell per handshake: traversed cells as free, endpoint as occupied. Clips cells outside the map and truncates over-long rays. Sits between the scan-to-cell converter and the occupancy map update.

Parameters:
X_BITS, 5, width of x_index; grid width = 2**X_BITS
Y_BITS, 4, width of y_index; grid height = 2**Y_BITS
COORD_W, 16, width of signed input cell coordinates (two's complement)
MAX_STEPS, 64, maximum cells traversed per ray, including clipped cells (>=1)
MARK_HIT, 1, 1 = emit endpoint with cell_is_free=0; 0 = endpoint not emitted

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; accepted only when busy=0
x0  in  COORD_W  signed sensor cell x, sampled on accepted start
y0  in  COORD_W  signed sensor cell y, sampled on accepted start
x1  in  COORD_W  signed hit cell x, sampled on accepted start
y1  in  COORD_W  signed hit cell y, sampled on accepted start
cell_valid  out  1  x_index/y_index/cell_is_free hold a cell
cell_ready  in  1  downstream accepts cell when cell_valid&cell_ready
x_index  out  X_BITS  cell column
y_index  out  Y_BITS  cell row
cell_is_free  out  1  1 = traversed (free), 0 = hit (occupied)
busy  out  1  ray in progress
done  out  1  one-cycle pulse when ray finishes or truncates
truncated  out  1  valid with done: ray stopped by MAX_STEPS

Behaviour:
- Reset (reset=0, async): state IDLE; cell_valid, busy, done, truncated, cell_is_free=0; x_index, y_index=0; internal step counter=0.
- States: IDLE, INIT, WALK, EMIT, FINISH.
- IDLE: start=1 latches x0..y1, -> INIT, busy=1 next cycle. start while busy ignored, no effect.
- INIT (1 cycle): dx=|x1-x0|, dy=|y1-y0|, sx=+1 if x1>=x0 else -1, sy likewise; err=dx-dy; cur=(x0,y0); steps=0. Arithmetic in COORD_W+2 signed bits, no overflow possible.
- WALK (1 cycle per cell): last = (cur==(x1,y1)). in_grid = 0<=cur.x<2**X_BITS and 0<=cur.y<2**Y_BITS.
  - in_grid and (!last or MARK_HIT=1): drive x_index/y_index=cur low bits, cell_is_free=!last, cell_valid=1, -> EMIT.
  - otherwise (clipped cell or unemitted endpoint): no output; advance directly (stays WALK or -> FINISH if last).
- EMIT: hold all outputs stable while cell_ready=0. On handshake: cell_valid=0 next cycle; if last -> FINISH else advance, -> WALK.
- Advance: steps+=1; e2=2*err; if e2>-dy: err-=dy, cur.x+=sx; if e2<dy: err+=dx, cur.y+=sy. If steps reaches MAX_STEPS before last cell: truncated=1, -> FINISH.
- FINISH (1 cycle): done=1 (truncated=1 iff truncation), busy=0 next cycle, -> IDLE. truncated clears with done.
- Latency: start -> first cell_valid = 3 cycles (IDLE, INIT, WALK); with cell_ready held 1, one cell every 2 cycles.
- Degenerate ray (x0,y0)==(x1,y1): single endpoint only; with MARK_HIT=0 no cells, done after INIT+WALK+FINISH.
- Endpoint always counted in steps; a ray of exactly MAX_STEPS cells completes without truncation.
- Reset mid-ray: outputs return to reset values immediately; no partial done.

Test Plan:
- Defaults, (0,0)->(5,0), cell_ready=1 -> cells (0..4,0) free, (5,0) occupied, done=1, truncated=0, first cell_valid 3 cycles after start.
- (3,10)->(0,2) steep negative -> 9 cells, each y step exactly once, x monotone non-increasing, last (0,2) occupied; matches software Bresenham model.
- (-2,-1)->(3,1) -> cells with x<0 suppressed, first emitted cell x=0, no gaps in emitted set vs model; MARK_HIT=0 build -> (3,1) not emitted.
- (0,0)->(31,15) with cell_ready toggled randomly -> outputs stable while stalled, no cell lost or duplicated; second start during busy ignored.
- MAX_STEPS=8, (0,0)->(20,0) -> cells x=0..7 free, no occupied cell, done with truncated=1; (0,0)->(7,0) -> completes, truncated=0.
- Assert reset=0 while cell_valid=1 mid-ray -> cell_valid, busy, done drop immediately; next start runs a clean ray.
